// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT carrier link: FSM states, frequency limits
// and the half-period helper used by both the transmitter and the receiver PLL.
package swipt_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DIV  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ_DEF         = 100000000;
  localparam int unsigned F_DEFAULT_DEF      = 40000;
  localparam int unsigned F_MIN              = 20000;
  localparam int unsigned F_MAX              = 100000;
  localparam int unsigned SETTLE_PERIODS_DEF = 4;

  // floor(clk_hz / (2*f)), never below one cycle
  function automatic logic [31:0] half_period(input logic [31:0] clk_hz,
                                              input logic [31:0] f);
    logic [31:0] q;
    if (f == 32'd0) begin
      q = 32'd1;
    end else begin
      q = clk_hz / (f << 1);
    end
    return (q == 32'd0) ? 32'd1 : q;
  endfunction

  localparam logic [31:0] HP_DEFAULT = half_period(CLK_HZ_DEF, F_DEFAULT_DEF);

endpackage

// File: rtl/seq_div32.sv
// Restoring unsigned 32/32 divider: 32 iteration cycles plus one cycle to
// register the quotient; done is a one-cycle pulse 33 cycles after start.
module seq_div32 (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic        done
);

  logic [31:0] rem;
  logic [31:0] q;
  logic [31:0] d;
  logic [5:0]  cnt;
  logic        busy;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;

  always_comb begin
    rem_sh  = {rem, q[31]};
    rem_sub = rem_sh[31:0] - d;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rem      <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= '0;
        q    <= dividend;
        d    <= divisor;
        cnt  <= 6'd32;
        busy <= 1'b1;
      end else if (busy) begin
        if (cnt != 6'd0) begin
          if (rem_sh >= {1'b0, d}) begin
            rem <= rem_sub;
            q   <= {q[30:0], 1'b1};
          end else begin
            rem <= rem_sh[31:0];
            q   <= {q[30:0], 1'b0};
          end
          cnt <= cnt - 6'd1;
        end else begin
          quotient <= q;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/swipt_carrier_tx.sv
// SWIPT transmit carrier: programmable square wave with phase-continuous
// frequency switching at the end of a high half, plus settle indication.
module swipt_carrier_tx
  import swipt_pkg::state_t, swipt_pkg::RUN, swipt_pkg::DIV, swipt_pkg::PEND,
         swipt_pkg::half_period;
#(
  parameter int unsigned CLK_HZ         = swipt_pkg::CLK_HZ_DEF,
  parameter int unsigned F_DEFAULT      = swipt_pkg::F_DEFAULT_DEF,
  parameter int unsigned F_MIN          = swipt_pkg::F_MIN,
  parameter int unsigned F_MAX          = swipt_pkg::F_MAX,
  parameter int unsigned SETTLE_PERIODS = swipt_pkg::SETTLE_PERIODS_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic [31:0] freq_in,
  input  logic        freq_valid,
  output logic        freq_ready,
  output logic        link,
  output logic        freq_rdy,
  output logic [31:0] f_active,
  output logic        err
);

  localparam logic [31:0] HP_RST   = half_period(32'(CLK_HZ), 32'(F_DEFAULT));
  localparam logic [7:0]  SETTLE_N = 8'(SETTLE_PERIODS);

  state_t      state;
  state_t      state_n;
  logic [31:0] hp;
  logic [31:0] hp_next;
  logic [31:0] hp_load;
  logic [31:0] cnt;
  logic [31:0] f_lat;
  logic [7:0]  settle;
  logic        err_n;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_q;
  logic        tog;
  logic        apply;

  seq_div32 u_div (
    .clk      (clk),
    .nrst     (nrst),
    .start    (div_start),
    .dividend (32'(CLK_HZ)),
    .divisor  (freq_in << 1),
    .quotient (div_q),
    .done     (div_done)
  );

  // A pending switch lands on the 1->0 toggle, or immediately if disabled.
  assign tog     = en && (cnt <= 32'd1);
  assign apply   = (state == PEND) && (!en || (tog && link));
  assign hp_load = apply ? hp_next : hp;

  always_comb begin
    state_n    = state;
    freq_ready = 1'b0;
    err_n      = 1'b0;
    div_start  = 1'b0;
    case (state)
      RUN: begin
        freq_ready = 1'b1;
        if (freq_valid) begin
          if (freq_in < 32'(F_MIN) || freq_in > 32'(F_MAX)) begin
            err_n = 1'b1;
          end else begin
            div_start = 1'b1;
            state_n   = DIV;
          end
        end
      end
      DIV: begin
        if (div_done) state_n = PEND;
      end
      PEND: begin
        if (apply) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= RUN;
      hp       <= HP_RST;
      hp_next  <= HP_RST;
      cnt      <= HP_RST;
      link     <= 1'b0;
      settle   <= '0;
      freq_rdy <= 1'b0;
      f_active <= 32'(F_DEFAULT);
      f_lat    <= 32'(F_DEFAULT);
      err      <= 1'b0;
    end else begin
      state <= state_n;
      err   <= err_n;
      if (div_start) f_lat <= freq_in;
      if (div_done && state == DIV) hp_next <= (div_q == 32'd0) ? 32'd1 : div_q;

      if (!en) begin
        link     <= 1'b0;
        cnt      <= hp_load;
        settle   <= '0;
        freq_rdy <= 1'b0;
      end else if (tog) begin
        link <= ~link;
        cnt  <= hp_load;
        if (!link && settle != SETTLE_N) begin
          settle <= settle + 8'd1;
          if (settle + 8'd1 == SETTLE_N) freq_rdy <= 1'b1;
        end
      end else begin
        cnt <= cnt - 32'd1;
      end

      if (apply) begin
        hp       <= hp_next;
        f_active <= f_lat;
        freq_rdy <= 1'b0;
        settle   <= '0;
      end
    end
  end

endmodule
